// File: rtl/checksum_pkg.sv
// Shared types, constants and the end-around-carry add used by the checksum engine.
package checksum_pkg;

  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] CS_ALL_ONES = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } cs_state_t;

  // One-pass fold is sufficient: a 16+16 sum plus its carry can never carry again.
  function automatic logic [DATA_W-1:0] ones_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DATA_W-1:0] + {{(DATA_W-1){1'b0}}, s[DATA_W]};
  endfunction

endpackage

// File: rtl/checksum_accumulator_if.sv
// Stream, status and downstream-counter signals of the checksum engine.
interface checksum_accumulator_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              data_valid;
  logic [DATA_W-1:0] data_in;
  logic              data_last;
  logic              data_ready;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] checksum;
  logic [CNT_W-1:0]  word_count;
  logic              cnt_en;
  logic              cnt_clr;

  modport master (
    output start, data_valid, data_in, data_last,
    input  data_ready, busy, done, checksum, word_count, cnt_en, cnt_clr
  );

  modport slave (
    input  start, data_valid, data_in, data_last,
    output data_ready, busy, done, checksum, word_count, cnt_en, cnt_clr
  );
endinterface

// File: rtl/checksum_accumulator_ones_adder.sv
// Combinational 16-bit ones-complement adder with end-around carry.
module ones_adder
  import checksum_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);
  assign sum = ones_add(a, b);
endmodule

// File: rtl/checksum_accumulator.sv
// Streaming RFC 1071 checksum engine; drives a downstream word counter.
// Define CHECKSUM_VERIFY_EN to add the registered 'match' (frame verifies) output.
module checksum_accumulator
  import checksum_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic clk,
  input  logic clear,
  checksum_accumulator_if.slave bus
`ifdef CHECKSUM_VERIFY_EN
  ,
  output logic match
`endif
);

  cs_state_t         state, state_nxt;
  logic [DATA_W-1:0] acc, acc_nxt;
  logic [DATA_W-1:0] checksum_q;
  logic [CNT_W-1:0]  word_count_q;
  logic              done_q;
  logic              accept;
  logic              start_ok;

  ones_adder u_ones_adder (
    .a   (acc),
    .b   (bus.data_in),
    .sum (acc_nxt)
  );

  always_ff @(posedge clk) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    start_ok  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          start_ok  = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        accept = bus.data_valid;
        if (bus.data_valid && bus.data_last) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      acc          <= '0;
      checksum_q   <= '0;
      word_count_q <= '0;
      done_q       <= 1'b0;
`ifdef CHECKSUM_VERIFY_EN
      match        <= 1'b0;
`endif
    end else begin
      done_q <= accept && bus.data_last;
      if (start_ok) begin
        acc          <= '0;
        word_count_q <= '0;
`ifdef CHECKSUM_VERIFY_EN
        match        <= 1'b0;
`endif
      end else if (accept) begin
        acc          <= acc_nxt;
        word_count_q <= word_count_q + CNT_W'(1);
        if (bus.data_last) begin
          checksum_q <= ~acc_nxt;
`ifdef CHECKSUM_VERIFY_EN
          match      <= (acc_nxt == CS_ALL_ONES);
`endif
        end
      end
    end
  end

  assign bus.data_ready = (state == ACCUM);
  assign bus.busy       = (state == ACCUM);
  assign bus.done       = done_q;
  assign bus.checksum   = checksum_q;
  assign bus.word_count = word_count_q;
  // clear also clears the downstream counter so it tracks word_count through a reset.
  assign bus.cnt_en     = accept & ~clear;
  assign bus.cnt_clr    = clear | start_ok;

endmodule
